// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle for mux_sel_pipe. The upstream producer, the downstream consumer
// and the error-clear control are grouped here; clk and reset_n stay plain ports.
interface mux_sel_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3
);
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_flat;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic                    err_clr;

  modport master (
    output sel, in_flat, in_valid, out_ready, err_clr,
    input  in_ready, out, out_sel, out_err, out_valid, sel_err
  );

  modport slave (
    input  sel, in_flat, in_valid, out_ready, err_clr,
    output in_ready, out, out_sel, out_err, out_valid, sel_err
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// N:1 word selector with a registered output stage and a one-deep skid buffer.
// Out-of-range selects yield DEFAULT_VAL, flag the beat and set a sticky error.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | output register empty, skid empty
//   ST_BUSY  | output register holds a beat, skid empty
//   ST_FULL  | output register and skid both hold a beat
module mux_sel_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 5,
  parameter int               SEL_W       = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input logic            clk,
  input logic            reset_n,
  mux_sel_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] out_q, skid_q;
  logic [SEL_W-1:0] out_sel_q, skid_sel_q;
  logic             out_err_q, skid_err_q;
  logic             out_valid_q, in_ready_q, sel_err_q;

  logic [WIDTH-1:0] new_word;
  logic             new_err;
  logic             accept, pop;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  // Default to the out-of-range result; a matching legal channel overrides it.
  always_comb begin
    new_word = DEFAULT_VAL;
    new_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        new_word = bus.in_flat[k*WIDTH +: WIDTH];
        new_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_EMPTY;
      out_q       <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      skid_q      <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      sel_err_q   <= 1'b0;
    end else begin
      // A new error outranks a clear in the same cycle.
      if (accept && new_err)
        sel_err_q <= 1'b1;
      else if (bus.err_clr)
        sel_err_q <= 1'b0;

      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_q       <= new_word;
            out_sel_q   <= bus.sel;
            out_err_q   <= new_err;
            out_valid_q <= 1'b1;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (pop) begin
            if (accept) begin
              out_q     <= new_word;
              out_sel_q <= bus.sel;
              out_err_q <= new_err;
            end else begin
              out_valid_q <= 1'b0;
              state       <= ST_EMPTY;
            end
          end else if (accept) begin
            skid_q     <= new_word;
            skid_sel_q <= bus.sel;
            skid_err_q <= new_err;
            in_ready_q <= 1'b0;
            state      <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            out_q      <= skid_q;
            out_sel_q  <= skid_sel_q;
            out_err_q  <= skid_err_q;
            in_ready_q <= 1'b1;
            state      <= ST_BUSY;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: a 5-input/32-bit instance and an 8-input/16-bit
// instance, directed beats with hand-computed expected words.
module tb_mux_sel_pipe;

  logic clk;
  logic reset_n;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  s;
    logic        e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Hand-computed expected words per select code (0 where out of range).
  logic [31:0] exp_a [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h0, 32'h0, 32'h0};
  logic [15:0] exp_b [8] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404,
                             16'h0505, 16'h0606, 16'h0707, 16'h0808};

  mux_sel_pipe_if #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) bus_a ();
  mux_sel_pipe_if #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) bus_b ();

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .DEFAULT_VAL(32'h0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  mux_sel_pipe #(.WIDTH(16), .NUM_IN(8), .SEL_W(3), .DEFAULT_VAL(16'h0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Present one beat on instance A and return #1 after the edge that accepted it.
  task automatic beat_a(input logic [2:0] s);
    logic acc;
    bit   done;
    exp_t e;
    bus_a.sel      = s;
    bus_a.in_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = bus_a.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        e.w = exp_a[s];
        e.s = s;
        e.e = (s > 3'd4);
        qa.push_back(e);
        done = 1;
      end
    end
    if (!done) check("beat_a_timeout", 32'd0, 32'd1);
  endtask

  task automatic beat_b(input logic [2:0] s);
    logic acc;
    bit   done;
    exp_t e;
    bus_b.sel      = s;
    bus_b.in_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = bus_b.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        e.w = {16'h0, exp_b[s]};
        e.s = s;
        e.e = 1'b0;
        qb.push_back(e);
        done = 1;
      end
    end
    if (!done) check("beat_b_timeout", 32'd0, 32'd1);
  endtask

  // Monitor A: pops on every handshake and checks stability while stalled.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_out;
    logic [2:0]  prev_sel;
    logic        prev_err;
    prev_stall = 1'b0;
    prev_out   = '0;
    prev_sel   = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall && bus_a.out_valid) begin
        check("a_stall_out", bus_a.out, prev_out);
        check("a_stall_sel", {29'h0, bus_a.out_sel}, {29'h0, prev_sel});
        check("a_stall_err", {31'h0, bus_a.out_err}, {31'h0, prev_err});
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (qa.size() == 0) begin
          check("a_unexpected_beat", {29'h0, bus_a.out_sel}, 32'hFFFF_FFFF);
        end else begin
          e = qa.pop_front();
          check("a_out", bus_a.out, e.w);
          check("a_out_sel", {29'h0, bus_a.out_sel}, {29'h0, e.s});
          check("a_out_err", {31'h0, bus_a.out_err}, {31'h0, e.e});
        end
      end
      prev_stall = bus_a.out_valid && !bus_a.out_ready;
      prev_out   = bus_a.out;
      prev_sel   = bus_a.out_sel;
      prev_err   = bus_a.out_err;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (qb.size() == 0) begin
          check("b_unexpected_beat", {29'h0, bus_b.out_sel}, 32'hFFFF_FFFF);
        end else begin
          e = qb.pop_front();
          check("b_out", {16'h0, bus_b.out}, e.w);
          check("b_out_sel", {29'h0, bus_b.out_sel}, {29'h0, e.s});
          check("b_out_err", {31'h0, bus_b.out_err}, 32'h0);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset_n        = 1'b0;
    bus_a.in_flat  = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    bus_a.sel      = 3'd0;
    bus_a.in_valid = 1'b1;
    bus_a.out_ready = 1'b1;
    bus_a.err_clr  = 1'b0;
    bus_b.in_flat  = {16'h0808, 16'h0707, 16'h0606, 16'h0505,
                      16'h0404, 16'h0303, 16'h0202, 16'h0101};
    bus_b.sel      = 3'd0;
    bus_b.in_valid = 1'b0;
    bus_b.out_ready = 1'b1;
    bus_b.err_clr  = 1'b0;

    // Reset held with in_valid high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, bus_a.out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, bus_a.in_ready}, 32'h1);
    check("rst_sel_err", {31'h0, bus_a.sel_err}, 32'h0);
    check("rst_out", bus_a.out, 32'h0);
    check("rst_out_sel", {29'h0, bus_a.out_sel}, 32'h0);
    check("rst_out_err", {31'h0, bus_a.out_err}, 32'h0);
    bus_a.in_valid = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming, full throughput.
    for (int s = 0; s < 5; s++) begin
      beat_a(3'(s));
      check("stream_out_valid", {31'h0, bus_a.out_valid}, 32'h1);
      check("stream_out", bus_a.out, exp_a[s]);
      check("stream_in_ready", {31'h0, bus_a.in_ready}, 32'h1);
    end
    bus_a.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: fill output and skid, stall, then drain in order.
    bus_a.out_ready = 1'b0;
    beat_a(3'd2);
    beat_a(3'd3);
    check("stall_in_ready", {31'h0, bus_a.in_ready}, 32'h0);
    check("stall_out", bus_a.out, 32'h33);
    bus_a.sel = 3'd4;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("stall_hold_out", bus_a.out, 32'h33);
      check("stall_hold_in_ready", {31'h0, bus_a.in_ready}, 32'h0);
    end
    bus_a.out_ready = 1'b1;
    beat_a(3'd4);
    beat_a(3'd0);
    bus_a.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_drained", qa.size(), 32'd0);

    // Out-of-range selects and sticky error.
    beat_a(3'd6);
    check("err_set", {31'h0, bus_a.sel_err}, 32'h1);
    check("err_out_err", {31'h0, bus_a.out_err}, 32'h1);
    check("err_out_default", bus_a.out, 32'h0);
    beat_a(3'd1);
    bus_a.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("err_sticky", {31'h0, bus_a.sel_err}, 32'h1);
    bus_a.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus_a.err_clr = 1'b0;
    check("err_cleared", {31'h0, bus_a.sel_err}, 32'h0);
    bus_a.err_clr = 1'b1;
    beat_a(3'd7);
    bus_a.err_clr = 1'b0;
    bus_a.in_valid = 1'b0;
    check("err_set_wins", {31'h0, bus_a.sel_err}, 32'h1);
    bus_a.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus_a.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation with output and skid full.
    bus_a.out_ready = 1'b0;
    beat_a(3'd1);
    beat_a(3'd2);
    bus_a.in_valid = 1'b0;
    check("pre_rst_in_ready", {31'h0, bus_a.in_ready}, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, bus_a.out_valid}, 32'h0);
    check("midrst_in_ready", {31'h0, bus_a.in_ready}, 32'h1);
    qa.delete();
    #1 reset_n = 1'b1;
    bus_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_idle", {31'h0, bus_a.out_valid}, 32'h0);
    beat_a(3'd3);
    check("postrst_latency", {31'h0, bus_a.out_valid}, 32'h1);
    check("postrst_out", bus_a.out, 32'h44);
    bus_a.in_valid = 1'b0;

    // Eight-channel instance: every code legal.
    for (int s = 0; s < 8; s++) beat_b(3'(s));
    bus_b.in_valid = 1'b0;

    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    #1;
    check("final_qa_empty", qa.size(), 32'd0);
    check("final_qb_empty", qb.size(), 32'd0);
    check("b_sel_err", {31'h0, bus_b.sel_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised N:1 word selector with a registered, flow-controlled output stage. Successor to the fixed 5-input datapath selector.
- Each accepted beat captures one input word chosen by the select code that arrives with that beat.
- A one-deep skid buffer gives full throughput under backpressure.
- Out-of-range select codes produce a defined default word and raise error flags. They never hold stale data.
- Sits between register-file/ALU sources and pipelined consumers in the datapath.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 5, number of input channels; legal range 2..2^SEL_W.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NUM_IN.
- DEFAULT_VAL, 0, WIDTH-bit word output for an out-of-range select.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- sel  input  SEL_W  channel select; sampled with the beat.
- in_flat  input  NUM_IN*WIDTH  concatenated inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- out  output  WIDTH  selected word.
- out_sel  output  SEL_W  select code captured with the current output beat.
- out_err  output  1  current output beat had an out-of-range select.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- sel_err  output  1  sticky error: an out-of-range select was accepted.
- err_clr  input  1  synchronous clear of sel_err.

Behaviour:
- Reset (reset_n low, asynchronous): out=0, out_sel=0, out_err=0, out_valid=0, sel_err=0, skid empty, in_ready=1.
- Data is registered only. There is no combinational path from in_flat/sel to out.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Beat capture: word = in_flat[sel*WIDTH +: WIDTH] when sel < NUM_IN. Otherwise word = DEFAULT_VAL and err bit = 1. sel is stored as-is in both cases.
- Output register update each clock:
  - If !out_valid or pop:
    - skid full: output <= skid, skid empties, out_valid=1.
    - else if accept: output <= new beat, out_valid=1.
    - else: out_valid <= 0; out/out_sel/out_err hold their last values.
  - If out_valid & !out_ready: output holds. If accept, the new beat goes to skid and skid becomes full.
- in_ready = !skid_full. It is derived from a register only, with no combinational dependence on out_ready.
- Latency: 1 cycle from accept to out_valid when the output is empty or popping. Throughput is 1 beat/cycle while out_ready=1.
- Ordering is strictly preserved; no beat is dropped or duplicated.
- While out_valid=1 and out_ready=0, out/out_sel/out_err are stable.
- sel_err: set on the clock where an accepted beat has an out-of-range select. Cleared by err_clr. If set and clear occur in the same cycle, set wins.
- sel changes while in_valid=0 have no effect.
- Reset asserted mid-operation discards both the output and skid entries immediately.

Test Plan:
- Reset with in_valid=1, in_flat channels = 0x11..0x55 -> out_valid=0, in_ready=1, sel_err=0, out=0.
- Stream sel=0,1,2,3,4 on consecutive cycles with out_ready=1 -> out = 0x11,0x22,0x33,0x44,0x55 one cycle after each accept; out_valid high 5 cycles; in_ready stays 1.
- Continuous in_valid, sel=2,3,4,0; hold out_ready=0 for 3 cycles after first accept -> in_ready drops after the 2nd accept; out held at 0x33 during the stall; after release the outputs are 0x33,0x44,0x55,0x11, with no loss.
- Accept sel=6 (NUM_IN=5) -> out=DEFAULT_VAL (0), out_err=1, out_sel=6, sel_err=1. sel_err stays 1 through later legal beats until err_clr pulses; err_clr in the same cycle as another sel=7 accept leaves sel_err=1.
- Fill output and skid (out_ready=0), then pulse reset_n low between clock edges -> out_valid=0 and in_ready=1 immediately; after release the first beat appears with 1-cycle latency.
- Instance NUM_IN=8, SEL_W=3, WIDTH=16: sel=0..7 -> all eight channels selectable, out_err never set.
